oscillo_readout: RTL

Readout engine for the oscilloscope sample RAM. It waits for a completed capture, then reads the stored window back out of RAM. The window starts `triggerpoint` samples before the recorded trigger address, is `nsmp` samples long, and wraps at the RAM boundary. Each enabled channel's bytes are streamed in turn over a valid/ready byte interface toward the host link. It sits between the capture block's RAM read port (`rden`/`rdaddress`, 1-cycle read latency) and the serial/USB transmitter, and can re-arm acquisition when the dump completes.

---
 rtl/oscillo_readout_if.sv | 41 ++++
 rtl/oscillo_readout.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/oscillo_readout_if.sv
// Bus bundle between the oscilloscope readout engine and its surroundings.
// It carries the capture status and request inputs, the latched dump
// parameters, the RAM read port and the byte stream toward the host link.
// The engine uses the slave view. The master view is for whatever drives it.
interface oscillo_readout_if #(
    parameter int ram_width = 10
);
    logic                 data_ready;
    logic                 readreq;
    logic [3:0]           chanmask;
    logic                 autorearm;
    logic [ram_width-1:0] wraddress_triggerpoint;
    logic [ram_width-1:0] triggerpoint;
    logic [ram_width-1:0] nsmp;
    logic [7:0]           ram_q1;
    logic [7:0]           ram_q2;
    logic [7:0]           ram_q3;
    logic [7:0]           ram_q4;
    logic                 rden;
    logic [ram_width-1:0] rdaddress;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic                 done;
    logic                 rearm;

    modport slave (
        input  data_ready, readreq, chanmask, autorearm,
        input  wraddress_triggerpoint, triggerpoint, nsmp,
        input  ram_q1, ram_q2, ram_q3, ram_q4, tx_ready,
        output rden, rdaddress, tx_data, tx_valid, busy, done, rearm
    );

    modport master (
        output data_ready, readreq, chanmask, autorearm,
        output wraddress_triggerpoint, triggerpoint, nsmp,
        output ram_q1, ram_q2, ram_q3, ram_q4, tx_ready,
        input  rden, rdaddress, tx_data, tx_valid, busy, done, rearm
    );
endinterface

// File: rtl/oscillo_readout.sv
// Readout engine for the oscilloscope sample RAM. Once a capture is complete,
// a read request dumps the stored window. The window starts triggerpoint
// samples before the trigger address, holds nsmp samples and wraps at the RAM
// boundary. Each enabled channel is sent in turn, oldest sample first. Bytes
// go out over a valid/ready interface. Each byte costs one RAM read, one
// cycle of RAM latency and then the handshake.
module oscillo_readout #(
    parameter int ram_width = 10
) (
    input  logic              clk,
    input  logic              reset,
    oscillo_readout_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        FINISH
    } state_t;

    localparam logic [ram_width-1:0] LP_ONE = ram_width'(1);

    state_t               r_state;
    logic [3:0]           r_mask;
    logic [ram_width-1:0] r_nsmp;
    logic [ram_width-1:0] r_start;
    logic [ram_width-1:0] r_idx;
    logic                 r_autorearm;
    logic [1:0]           r_ch;
    logic                 r_rden;
    logic [ram_width-1:0] r_rdaddress;
    logic [7:0]           r_txData;
    logic                 r_txValid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_rearm;

    logic [ram_width-1:0] w_start;
    logic                 w_lastSample;
    logic [1:0]           w_firstCh;
    logic [1:0]           w_nextCh;
    logic                 w_nextValid;
    logic [7:0]           w_ramSel;

    assign w_start      = bus.wraddress_triggerpoint - bus.triggerpoint;
    assign w_lastSample = (r_idx == (r_nsmp - LP_ONE));

    assign bus.rden      = r_rden;
    assign bus.rdaddress = r_rdaddress;
    assign bus.tx_data   = r_txData;
    assign bus.tx_valid  = r_txValid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rearm     = r_rearm;

    // Lowest enabled channel in the incoming mask, used when a dump starts
    always_comb begin
        w_firstCh = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.chanmask[i]) begin
                w_firstCh = 2'(i);
            end
        end
    end

    // Next enabled channel above the current one in the latched mask
    always_comb begin
        w_nextCh    = 2'd0;
        w_nextValid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_nextCh    = 2'(i);
                w_nextValid = 1'b1;
            end
        end
    end

    // RAM data lane of the channel currently being dumped
    always_comb begin
        case (r_ch)
            2'd0:    w_ramSel = bus.ram_q1;
            2'd1:    w_ramSel = bus.ram_q2;
            2'd2:    w_ramSel = bus.ram_q3;
            default: w_ramSel = bus.ram_q4;
        endcase
    end

    // Dump sequencer with registered outputs: read, wait out RAM latency, offer byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_nsmp      <= '0;
            r_start     <= '0;
            r_idx       <= '0;
            r_autorearm <= 1'b0;
            r_ch        <= '0;
            r_rden      <= 1'b0;
            r_rdaddress <= '0;
            r_txData    <= '0;
            r_txValid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rearm     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.readreq && bus.data_ready) begin
                        r_mask      <= bus.chanmask;
                        r_nsmp      <= bus.nsmp;
                        r_autorearm <= bus.autorearm;
                        r_start     <= w_start;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        if ((bus.chanmask == 4'd0) || (bus.nsmp == '0)) begin
                            r_done  <= 1'b1;
                            r_rearm <= bus.autorearm;
                            r_state <= FINISH;
                        end else begin
                            r_ch        <= w_firstCh;
                            r_rden      <= 1'b1;
                            r_rdaddress <= w_start;
                            r_state     <= READ;
                        end
                    end
                end
                READ: begin
                    r_rden  <= 1'b0;
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_txData  <= w_ramSel;
                    r_txValid <= 1'b1;
                    r_state   <= SEND;
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        r_txValid <= 1'b0;
                        if (!w_lastSample) begin
                            r_idx       <= r_idx + LP_ONE;
                            r_rden      <= 1'b1;
                            r_rdaddress <= r_start + r_idx + LP_ONE;
                            r_state     <= READ;
                        end else if (w_nextValid) begin
                            r_ch        <= w_nextCh;
                            r_idx       <= '0;
                            r_rden      <= 1'b1;
                            r_rdaddress <= r_start;
                            r_state     <= READ;
                        end else begin
                            r_done  <= 1'b1;
                            r_rearm <= r_autorearm;
                            r_state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_rearm <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
